mem_port_arbiter: RTL and testbench

- Parametrised N-channel arbiter that shares one single-port synchronous RAM (memory_ip class) between several requesters.
- Typical requesters are the processor datapath and the external loader/host.
- Replaces the ad-hoc per-memory muxing in the top layer with a req/gnt handshake, selectable fixed-priority or round-robin policy, and tagged read-return routing.
- One instance sits in front of each memory (instruction RAM, data RAM).

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous RAM between N_CH requesters. A
//   combinational one-hot grant picks one requester per cycle, using either
//   fixed priority (lowest index wins) or round-robin. The winning command is
//   registered onto the RAM port. Each read carries a channel tag down a shift
//   pipeline so the returning data is flagged on the right channel's rvalid.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req_i, we_i     per-channel request and write(1)/read(0) qualifier
//   addr_i, wdata_i packed per-channel address / write data (channel i at slice i)
//   gnt_o           one-hot combinational grant; transfer = req_i & gnt_o
//   rvalid_o        one-hot read-data-valid, RD_LAT+1 cycles after the grant edge
//   rdata_o         read data (RAM q passed through), qualified by rvalid_o
//   mem_addr_o, mem_wdata_o, mem_wren_o, mem_rden_o   registered RAM command
//   mem_q_i         RAM read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter int N_CH    = 2,
  parameter int RR_MODE = 0,
  parameter int RD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          we_i,
  input  logic [N_CH*ADDR_W-1:0]   addr_i,
  input  logic [N_CH*DATA_W-1:0]   wdata_i,
  output logic [N_CH-1:0]          gnt_o,
  output logic [N_CH-1:0]          rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     mem_wren_o,
  output logic                     mem_rden_o,
  input  logic [DATA_W-1:0]        mem_q_i
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0]   gnt_raw;
  logic [IDX_W-1:0]  gnt_idx;
  logic              xfer;
  logic              sel_we;
  logic [ADDR_W-1:0] addr_term  [N_CH];
  logic [DATA_W-1:0] wdata_term [N_CH];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              mem_rden_q, mem_rden_d;

  logic [RD_LAT:0]            tag_vld_q;
  logic [RD_LAT:0][IDX_W-1:0] tag_ch_q;

  // Grant search: walk the channels starting at the pointer (round-robin) or
  // at 0 (fixed priority), wrapping modulo N_CH; first requester wins.
  always_comb begin : grant_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_raw  = '0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = (RR_MODE != 0) ? int'(ptr_q) + k : k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = IDX_W'(cand);
      if ((gnt_raw == '0) && req_i[cand_idx]) begin
        gnt_raw[cand_idx] = 1'b1;
        gnt_idx           = cand_idx;
      end
    end
  end

  // No grant may escape while reset is held, even though req_i is live.
  assign gnt_o = gnt_raw & {N_CH{rst_n}};
  assign xfer  = |gnt_o;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // AND-OR select: a slice is masked by its own grant bit, so a non-granted
  // channel's (possibly undefined) inputs cannot reach the RAM command.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slice
      assign addr_term[gi]  = addr_i[gi*ADDR_W +: ADDR_W]  & {ADDR_W{gnt_raw[gi]}};
      assign wdata_term[gi] = wdata_i[gi*DATA_W +: DATA_W] & {DATA_W{gnt_raw[gi]}};
    end
  endgenerate

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_addr  = sel_addr  | addr_term[k];
      sel_wdata = sel_wdata | wdata_term[k];
    end
  end

  assign sel_we = |(we_i & gnt_raw);

  always_comb begin
    mem_addr_d  = xfer ? sel_addr  : mem_addr_q;
    mem_wdata_d = xfer ? sel_wdata : mem_wdata_q;
    mem_wren_d  = xfer & sel_we;
    mem_rden_d  = xfer & ~sel_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
    end
  end

  // Read-tag pipeline. Stage 0 is aligned with mem_rden_o; stage k is k cycles
  // later, so stage RD_LAT lines up with the RAM's q for that read.
  generate
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_vld_q[0] <= 1'b0;
            tag_ch_q[0]  <= '0;
          end else begin
            tag_vld_q[0] <= mem_rden_d;
            tag_ch_q[0]  <= gnt_idx;
          end
        end
      end else begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_vld_q[gi] <= 1'b0;
            tag_ch_q[gi]  <= '0;
          end else begin
            tag_vld_q[gi] <= tag_vld_q[gi-1];
            tag_ch_q[gi]  <= tag_ch_q[gi-1];
          end
        end
      end
    end

    for (gi = 0; gi < N_CH; gi++) begin : g_rvalid
      assign rvalid_o[gi] = tag_vld_q[RD_LAT] & (tag_ch_q[RD_LAT] == IDX_W'(gi));
    end
  endgenerate

  assign rdata_o     = mem_q_i;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wren_o  = mem_wren_q;
  assign mem_rden_o  = mem_rden_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiter instances: A = 2 channels, fixed priority, RD_LAT 1;
//   B = 4 channels, round-robin, RD_LAT 3. Each has a RAM stub and a reference
//   model that predicts grants from the arbitration rules, tracks the RAM
//   command it expects next cycle, and pushes expected read returns into a
//   scoreboard queue that is popped whenever the DUT raises rvalid.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NA = 2;
  localparam int LA = 1;
  localparam int NB = 4;
  localparam int LB = 3;

  typedef struct {
    int        ch;
    logic [DW-1:0] data;
    bit        dv;
    int        due;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_grant(input int n, input bit rr, input int ptr, input logic [3:0] rq);
    for (int k = 0; k < n; k++) begin
      int c;
      c = rr ? (ptr + k) % n : k;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- instance A ----------------
  logic [NA-1:0]    a_req, a_we, a_gnt, a_rvalid;
  logic [NA*AW-1:0] a_addr;
  logic [NA*DW-1:0] a_wdata;
  logic [DW-1:0]    a_rdata, a_mwdata, a_mq;
  logic [AW-1:0]    a_maddr;
  logic             a_mwren, a_mrden;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NA), .RR_MODE(0), .RD_LAT(LA)) u_a (
    .clk(clk), .rst_n(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_wren_o(a_mwren),
    .mem_rden_o(a_mrden), .mem_q_i(a_mq));

  // ---------------- instance B ----------------
  logic [NB-1:0]    b_req, b_we, b_gnt, b_rvalid;
  logic [NB*AW-1:0] b_addr;
  logic [NB*DW-1:0] b_wdata;
  logic [DW-1:0]    b_rdata, b_mwdata, b_mq;
  logic [AW-1:0]    b_maddr;
  logic             b_mwren, b_mrden;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NB), .RR_MODE(1), .RD_LAT(LB)) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_wren_o(b_mwren),
    .mem_rden_o(b_mrden), .mem_q_i(b_mq));

  // ---------------- RAM stubs (no reset, q after LAT edges) ----------------
  logic [DW-1:0] a_ram [512];
  logic [DW-1:0] a_pipe [LA];
  always @(posedge clk) begin
    if (a_mwren) a_ram[a_maddr] <= a_mwdata;
    a_pipe[0] <= a_mrden ? a_ram[a_maddr] : DW'($urandom);
    for (int i = 1; i < LA; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign a_mq = a_pipe[LA-1];

  logic [DW-1:0] b_ram [512];
  logic [DW-1:0] b_pipe [LB];
  always @(posedge clk) begin
    if (b_mwren) b_ram[b_maddr] <= b_mwdata;
    b_pipe[0] <= b_mrden ? b_ram[b_maddr] : DW'($urandom);
    for (int i = 1; i < LB; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_mq = b_pipe[LB-1];

  // ---------------- reference model + monitor, A ----------------
  logic [DW-1:0] a_ref [512];
  bit            a_refv [512];
  rd_t           a_q[$];
  rd_t           a_r;
  int            a_cyc = 0, a_ptr = 0, a_g = 0;
  logic [3:0]    a_egnt = '0;
  logic [AW-1:0] a_eaddr = '0;
  logic [DW-1:0] a_ewd = '0;
  logic          a_ewr = 1'b0, a_erd = 1'b0;

  always @(negedge clk) begin
    a_cyc++;
    if (!rst_n) begin
      check({a_mwren, a_mrden, a_maddr, a_mwdata, a_rvalid} == '0, "A reset outputs",
            {a_mwren, a_mrden, a_maddr, a_mwdata, a_rvalid}, 0);
      a_q.delete();
      a_ptr = 0; a_eaddr = '0; a_ewd = '0; a_ewr = 1'b0; a_erd = 1'b0;
    end else begin
      check({a_mwren, a_mrden} == {a_ewr, a_erd}, "A wren/rden", {a_mwren, a_mrden}, {a_ewr, a_erd});
      check(a_maddr == a_eaddr && a_mwdata == a_ewd, "A mem_addr/wdata",
            {a_maddr, a_mwdata}, {a_eaddr, a_ewd});
      if (a_rvalid != '0) begin
        if (a_q.size() == 0) check(1'b0, "A unexpected rvalid", a_rvalid, 0);
        else begin
          a_r = a_q.pop_front();
          check(a_rvalid == NA'(1 << a_r.ch) && a_cyc == a_r.due, "A rvalid ch/cycle",
                {a_rvalid, 32'(a_cyc)}, {NA'(1 << a_r.ch), 32'(a_r.due)});
          if (a_r.dv) check(a_rdata == a_r.data, "A rdata", a_rdata, a_r.data);
        end
      end else if (a_q.size() > 0 && a_q[0].due <= a_cyc) begin
        check(1'b0, "A missing rvalid", a_cyc, a_q[0].due);
        void'(a_q.pop_front());
      end
    end
    #1;
    a_g    = exp_grant(NA, 1'b0, a_ptr, rst_n ? 4'(a_req) : 4'b0);
    a_egnt = (a_g >= 0) ? 4'(1 << a_g) : 4'b0;
    check(4'(a_gnt) == a_egnt, "A gnt", a_gnt, a_egnt);
    if (rst_n && a_g >= 0) begin
      a_eaddr = a_addr[a_g*AW +: AW];
      a_ewd   = a_wdata[a_g*DW +: DW];
      a_ewr   = a_we[a_g];
      a_erd   = !a_we[a_g];
      if (a_we[a_g]) begin
        a_ref[a_eaddr]  = a_ewd;
        a_refv[a_eaddr] = 1'b1;
      end else begin
        a_q.push_back('{ch: a_g, data: a_ref[a_eaddr], dv: a_refv[a_eaddr], due: a_cyc + 1 + LA});
      end
      a_ptr = (a_g + 1) % NA;
    end else begin
      a_ewr = 1'b0;
      a_erd = 1'b0;
    end
  end

  // ---------------- reference model + monitor, B ----------------
  logic [DW-1:0] b_ref [512];
  bit            b_refv [512];
  rd_t           b_q[$];
  rd_t           b_r;
  int            b_cyc = 0, b_ptr = 0, b_g = 0;
  logic [3:0]    b_egnt = '0;
  logic [AW-1:0] b_eaddr = '0;
  logic [DW-1:0] b_ewd = '0;
  logic          b_ewr = 1'b0, b_erd = 1'b0;

  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      check({b_mwren, b_mrden, b_maddr, b_mwdata, b_rvalid} == '0, "B reset outputs",
            {b_mwren, b_mrden, b_maddr, b_mwdata, b_rvalid}, 0);
      b_q.delete();
      b_ptr = 0; b_eaddr = '0; b_ewd = '0; b_ewr = 1'b0; b_erd = 1'b0;
    end else begin
      check({b_mwren, b_mrden} == {b_ewr, b_erd}, "B wren/rden", {b_mwren, b_mrden}, {b_ewr, b_erd});
      check(b_maddr == b_eaddr && b_mwdata == b_ewd, "B mem_addr/wdata",
            {b_maddr, b_mwdata}, {b_eaddr, b_ewd});
      if (b_rvalid != '0) begin
        if (b_q.size() == 0) check(1'b0, "B unexpected rvalid", b_rvalid, 0);
        else begin
          b_r = b_q.pop_front();
          check(b_rvalid == NB'(1 << b_r.ch) && b_cyc == b_r.due, "B rvalid ch/cycle",
                {b_rvalid, 32'(b_cyc)}, {NB'(1 << b_r.ch), 32'(b_r.due)});
          if (b_r.dv) check(b_rdata == b_r.data, "B rdata", b_rdata, b_r.data);
        end
      end else if (b_q.size() > 0 && b_q[0].due <= b_cyc) begin
        check(1'b0, "B missing rvalid", b_cyc, b_q[0].due);
        void'(b_q.pop_front());
      end
    end
    #1;
    b_g    = exp_grant(NB, 1'b1, b_ptr, rst_n ? b_req : 4'b0);
    b_egnt = (b_g >= 0) ? 4'(1 << b_g) : 4'b0;
    check(b_gnt == b_egnt, "B gnt", b_gnt, b_egnt);
    if (rst_n && b_g >= 0) begin
      b_eaddr = b_addr[b_g*AW +: AW];
      b_ewd   = b_wdata[b_g*DW +: DW];
      b_ewr   = b_we[b_g];
      b_erd   = !b_we[b_g];
      if (b_we[b_g]) begin
        b_ref[b_eaddr]  = b_ewd;
        b_refv[b_eaddr] = 1'b1;
      end else begin
        b_q.push_back('{ch: b_g, data: b_ref[b_eaddr], dv: b_refv[b_eaddr], due: b_cyc + 1 + LB});
      end
      b_ptr = (b_g + 1) % NB;
    end else begin
      b_ewr = 1'b0;
      b_erd = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_a(input int ch, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req[ch] = 1'b1; a_we[ch] = w; a_addr[ch*AW +: AW] = ad; a_wdata[ch*DW +: DW] = d;
  endtask

  task automatic set_b(input int ch, input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_req[ch] = 1'b1; b_we[ch] = w; b_addr[ch*AW +: AW] = ad; b_wdata[ch*DW +: DW] = d;
  endtask

  // Random requesters: each holds its request until granted; idle channels
  // present garbage on their slices.
  task automatic rand_run(input int inst, input int cycles);
    bit            pend [4];
    bit            pwe  [4];
    logic [AW-1:0] pad  [4];
    logic [DW-1:0] pdt  [4];
    logic [3:0]    rq, wv, gv;
    logic [4*AW-1:0] av;
    logic [4*DW-1:0] dv;
    int n;
    n = (inst != 0) ? NB : NA;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (ch < n && !pend[ch] && $urandom_range(0, 2) != 0) begin
          pend[ch] = 1'b1;
          pwe[ch]  = 1'($urandom_range(0, 1));
          pad[ch]  = AW'($urandom_range(0, 15));
          pdt[ch]  = DW'($urandom);
        end
        rq[ch] = pend[ch];
        wv[ch] = pend[ch] ? pwe[ch] : 1'($urandom);
        av[ch*AW +: AW] = pend[ch] ? pad[ch] : AW'($urandom);
        dv[ch*DW +: DW] = pend[ch] ? pdt[ch] : DW'($urandom);
      end
      if (inst != 0) begin
        b_req = rq; b_we = wv; b_addr = av; b_wdata = dv;
      end else begin
        a_req = rq[NA-1:0]; a_we = wv[NA-1:0]; a_addr = av[NA*AW-1:0]; a_wdata = dv[NA*DW-1:0];
      end
      #2;
      gv = (inst != 0) ? b_gnt : 4'(a_gnt);
      for (int ch = 0; ch < 4; ch++) if (gv[ch]) pend[ch] = 1'b0;
    end
    @(negedge clk);
    a_req = '0;
    b_req = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // A: write 0xBEEF to 0x005 on ch1, then read it back after a gap
    @(negedge clk); set_a(1, 1'b1, 9'h005, 16'hBEEF);
    #2 check(a_gnt == 2'b10, "A write gnt", a_gnt, 2'b10);
    @(negedge clk); a_req = '0;
    #2 check(a_mwren && a_maddr == 9'h005 && a_mwdata == 16'hBEEF, "A write cmd",
             {a_mwren, a_maddr, a_mwdata}, {1'b1, 9'h005, 16'hBEEF});
    @(negedge clk);
    @(negedge clk); set_a(1, 1'b0, 9'h005, 16'h0000);
    #2 check(a_gnt == 2'b10, "A read gnt", a_gnt, 2'b10);
    @(negedge clk); a_req = '0;
    @(negedge clk);
    #2 check(a_rvalid == 2'b10 && a_rdata == 16'hBEEF, "A readback",
             {a_rvalid, a_rdata}, {2'b10, 16'hBEEF});

    // A: fixed priority with both channels requesting
    @(negedge clk); set_a(0, 1'b0, 9'h005, 16'h0); set_a(1, 1'b0, 9'h006, 16'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #2 check(a_gnt == 2'b01, "A fixed prio", a_gnt, 2'b01);
    end
    @(negedge clk); a_req[0] = 1'b0;
    #2 check(a_gnt == 2'b10, "A ch1 after drop", a_gnt, 2'b10);
    @(negedge clk); a_req = '0;

    // B: round-robin rotation with all four requesting, then 1010
    @(negedge clk);
    for (int ch = 0; ch < NB; ch++) set_b(ch, 1'b0, AW'(ch), 16'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #2 check(b_gnt == 4'(1 << (k % 4)), "B rr 1111", b_gnt, 4'(1 << (k % 4)));
    end
    @(negedge clk); b_req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #2 check(b_gnt == ((k % 2 == 0) ? 4'b0010 : 4'b1000), "B rr 1010", b_gnt,
               (k % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    @(negedge clk); b_req = '0;

    // B: preload then back-to-back reads, returns on consecutive cycles
    @(negedge clk); set_b(2, 1'b1, 9'h010, 16'h1111);
    @(negedge clk); set_b(2, 1'b1, 9'h011, 16'h2222);
    @(negedge clk); set_b(2, 1'b1, 9'h012, 16'h3333);
    @(negedge clk); b_req = '0;
    @(negedge clk); set_b(0, 1'b0, 9'h010, 16'h0);
    @(negedge clk); b_req = '0; set_b(1, 1'b0, 9'h011, 16'h0);
    @(negedge clk); b_req = '0; set_b(0, 1'b0, 9'h012, 16'h0);
    @(negedge clk); b_req = '0;
    @(negedge clk);
    #2 check(b_rvalid == 4'b0001 && b_rdata == 16'h1111, "B lat ret0", {b_rvalid, b_rdata}, {4'b0001, 16'h1111});
    @(negedge clk);
    #2 check(b_rvalid == 4'b0010 && b_rdata == 16'h2222, "B lat ret1", {b_rvalid, b_rdata}, {4'b0010, 16'h2222});
    @(negedge clk);
    #2 check(b_rvalid == 4'b0001 && b_rdata == 16'h3333, "B lat ret2", {b_rvalid, b_rdata}, {4'b0001, 16'h3333});

    // Random traffic on each instance
    rand_run(0, 300);
    rand_run(1, 300);
    repeat (6) @(negedge clk);

    // Reset one cycle after a read is granted; requests stay asserted
    @(negedge clk); set_a(0, 1'b0, 9'h005, 16'h0); set_b(1, 1'b0, 9'h010, 16'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check({a_gnt, a_rvalid, a_mwren, a_mrden, a_maddr, a_mwdata} == '0, "A async reset",
             {a_gnt, a_rvalid, a_mwren, a_mrden, a_maddr, a_mwdata}, 0);
    check({b_gnt, b_rvalid, b_mwren, b_mrden, b_maddr, b_mwdata} == '0, "B async reset",
          {b_gnt, b_rvalid, b_mwren, b_mrden, b_maddr, b_mwdata}, 0);
    @(negedge clk); a_req = '0; b_req = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk); b_req = 4'b1111;
    #2 check(b_gnt == 4'b0001, "B ptr after reset", b_gnt, 4'b0001);
    @(negedge clk); b_req = '0;

    repeat (10) @(negedge clk);
    check(a_q.size() == 0 && b_q.size() == 0, "scoreboard drained", a_q.size() + b_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
